// File: rtl/ppm_tx_framer.sv
// Buffered 4-PPM frame transmitter: FIFO-fed payload serialised as PRE, LEN, DATA, [CRC], GUARD.
// Define PPM_TX_CRC_EN to append a CRC-8 (poly 0x07) byte after the payload.
module ppm_tx_framer #(
    parameter int FIFO_AW  = 4,
    parameter int SLOT_DIV = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [7:0]         din,
    input  logic               le,
    input  logic [3:0]         n,
    output logic               dout,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               ovf,
    output logic [FIFO_AW:0]   fifo_cnt
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int SW    = (SLOT_DIV > 1) ? $clog2(SLOT_DIV) : 1;
    localparam logic [SW-1:0]    SLOT_LAST = SW'(SLOT_DIV - 1);
    localparam logic [FIFO_AW:0] CNT_FULL  = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_LEN, S_DATA,
`ifdef PPM_TX_CRC_EN
        S_CRC,
`endif
        S_GUARD
    } state_t;

    state_t               state_q, state_d;
    logic [SW-1:0]        slot_q, slot_d;
    logic [1:0]           sslot_q, sslot_d;
    logic [1:0]           sym_q, sym_d;
    logic [3:0]           byte_q, byte_d;
    logic [3:0]           len_q, len_d;
    logic [7:0]           shreg_q, shreg_d;
    logic                 dout_q, dout_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 ovf_q, ovf_d;
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     cnt_q, cnt_d;
    logic [7:0]           mem [DEPTH];
    logic                 pop, push, full, accept;

`ifdef PPM_TX_CRC_EN
    logic [7:0]           crc_q, crc_d;

    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        c = crc ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction
`endif

    assign full   = (cnt_q == CNT_FULL);
    assign accept = le && (state_q == S_IDLE) && (n != 4'd0) && (32'(cnt_q) >= 32'(n));

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        sslot_d = sslot_q;
        sym_d   = sym_q;
        byte_d  = byte_q;
        len_d   = len_q;
        shreg_d = shreg_q;
`ifdef PPM_TX_CRC_EN
        crc_d   = crc_q;
`endif
        pop     = 1'b0;
        done_d  = 1'b0;
        err_d   = le && !accept;

        if (state_q == S_IDLE) begin
            if (accept) begin
                state_d = S_PRE;
                slot_d  = '0;
                sslot_d = 2'd0;
                sym_d   = 2'd0;
                byte_d  = 4'd0;
                len_d   = n;
`ifdef PPM_TX_CRC_EN
                crc_d   = 8'h00;
`endif
            end
        end else if (slot_q == SLOT_LAST) begin
            slot_d  = '0;
            sslot_d = sslot_q + 2'd1;
            if (sslot_q == 2'd3) begin
                case (state_q)
                    S_PRE: begin
                        state_d = S_LEN;
                        shreg_d = {4'h0, len_q};
                        sym_d   = 2'd0;
                    end
                    S_GUARD: begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                    default: begin
                        if (sym_q != 2'd3) begin
                            sym_d   = sym_q + 2'd1;
                            shreg_d = {shreg_q[5:0], 2'b00};
                        end else begin
                            sym_d = 2'd0;
                            // Next payload byte is popped as the previous byte's last slot ends
                            if (state_q == S_LEN || (state_q == S_DATA && byte_q != len_q)) begin
                                state_d = S_DATA;
                                pop     = 1'b1;
                                shreg_d = mem[rd_ptr_q];
                                byte_d  = byte_q + 4'd1;
`ifdef PPM_TX_CRC_EN
                                crc_d   = crc8_update(crc_q, mem[rd_ptr_q]);
                            end else if (state_q == S_DATA) begin
                                state_d = S_CRC;
                                shreg_d = crc_q;
`endif
                            end else begin
                                state_d = S_GUARD;
                            end
                        end
                    end
                endcase
            end
        end else begin
            slot_d = slot_q + SW'(1);
        end

        // Line level is derived from the next-state view so dout is registered yet aligned
        case (state_d)
            S_IDLE, S_GUARD: dout_d = 1'b0;
            S_PRE:           dout_d = (sslot_d != 2'd3);
            default:         dout_d = (shreg_d[7:6] == sslot_d);
        endcase
    end

    always_comb begin
        push     = wr_en && (!full || pop);
        ovf_d    = wr_en && full && !pop;
        wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            slot_q   <= '0;
            sslot_q  <= 2'd0;
            sym_q    <= 2'd0;
            byte_q   <= 4'd0;
            len_q    <= 4'd0;
            dout_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            sslot_q  <= sslot_d;
            sym_q    <= sym_d;
            byte_q   <= byte_d;
            len_q    <= len_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
`ifdef PPM_TX_CRC_EN
        crc_q   <= crc_d;
`endif
        if (push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    assign dout     = dout_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign ovf      = ovf_q;
    assign fifo_cnt = cnt_q;

endmodule

// File: tb/tb_ppm_tx_framer.sv
// Randomised bench for ppm_tx_framer: two instances (SLOT_DIV 1 and 3) against a slot-level frame model.
module tb_ppm_tx_framer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       wr_a, le_a, dout_a, busy_a, done_a, err_a, ovf_a;
    logic [7:0] din_a;
    logic [3:0] n_a;
    logic [4:0] cnt_a;
    logic       wr_b, le_b, dout_b, busy_b, done_b, err_b, ovf_b;
    logic [7:0] din_b;
    logic [3:0] n_b;
    logic [4:0] cnt_b;

    ppm_tx_framer #(.FIFO_AW(4), .SLOT_DIV(1)) u_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_a), .din(din_a), .le(le_a), .n(n_a),
        .dout(dout_a), .busy(busy_a), .done(done_a), .err(err_a), .ovf(ovf_a), .fifo_cnt(cnt_a)
    );
    ppm_tx_framer #(.FIFO_AW(4), .SLOT_DIV(3)) u_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_b), .din(din_b), .le(le_b), .n(n_b),
        .dout(dout_b), .busy(busy_b), .done(done_b), .err(err_b), .ovf(ovf_b), .fifo_cnt(cnt_b)
    );

    int cur_sel = 0;
    logic       dout_s, busy_s, done_s, err_s, ovf_s;
    logic [4:0] cnt_s;
    assign dout_s = (cur_sel == 0) ? dout_a : dout_b;
    assign busy_s = (cur_sel == 0) ? busy_a : busy_b;
    assign done_s = (cur_sel == 0) ? done_a : done_b;
    assign err_s  = (cur_sel == 0) ? err_a  : err_b;
    assign ovf_s  = (cur_sel == 0) ? ovf_a  : ovf_b;
    assign cnt_s  = (cur_sel == 0) ? cnt_a  : cnt_b;

    int checks = 0;
    int failures = 0;
    logic [7:0] mq_a[$];
    logic [7:0] mq_b[$];
    logic [7:0] pay[$];
    bit         exp_bits[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int sel);
        return (sel == 0) ? mq_a.size() : mq_b.size();
    endfunction

    function automatic int frame_slots(input int nn);
`ifdef PPM_TX_CRC_EN
        return 4 + 16 + 16 * nn + 16 + 4;
`else
        return 4 + 16 + 16 * nn + 4;
`endif
    endfunction

    task automatic set_wr(input int sel, input logic w, input logic [7:0] d);
        if (sel == 0) begin wr_a = w; din_a = d; end
        else          begin wr_b = w; din_b = d; end
    endtask

    task automatic set_le(input int sel, input logic l, input logic [3:0] nn);
        if (sel == 0) begin le_a = l; n_a = nn; end
        else          begin le_b = l; n_b = nn; end
    endtask

    // One PPM byte: four MSB-first symbols, each a one-hot group of 4 slots
    function automatic void add_byte(input logic [7:0] b);
        for (int s = 3; s >= 0; s--) begin
            int v;
            v = (int'(b) >> (2 * s)) & 3;
            for (int k = 0; k < 4; k++) exp_bits.push_back(k == v);
        end
    endfunction

`ifdef PPM_TX_CRC_EN
    function automatic logic [7:0] crc_ref();
        logic [7:0] c;
        c = 8'h00;
        foreach (pay[i]) begin
            for (int j = 7; j >= 0; j--) begin
                logic fb;
                fb = c[7] ^ pay[i][j];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction
`endif

    function automatic void build_exp(input int nn);
        exp_bits.delete();
        exp_bits.push_back(1); exp_bits.push_back(1); exp_bits.push_back(1); exp_bits.push_back(0);
        add_byte(8'(nn));
        foreach (pay[i]) add_byte(pay[i]);
`ifdef PPM_TX_CRC_EN
        add_byte(crc_ref());
`endif
        for (int k = 0; k < 4; k++) exp_bits.push_back(0);
    endfunction

    task automatic push(input int sel, input logic [7:0] b);
        bit full_exp;
        cur_sel  = sel;
        full_exp = (qsize(sel) >= 16);
        set_wr(sel, 1'b1, b);
        @(negedge clk);
        set_wr(sel, 1'b0, 8'h00);
        if (!full_exp) begin
            if (sel == 0) mq_a.push_back(b); else mq_b.push_back(b);
        end
        check("ovf", ovf_s, full_exp);
        check("fifo_cnt_push", cnt_s, qsize(sel));
    endtask

    task automatic issue_le(input int sel, input int nn, output bit ok);
        cur_sel = sel;
        ok = !busy_s && (nn != 0) && (qsize(sel) >= nn);
        set_le(sel, 1'b1, 4'(nn));
        @(negedge clk);
        set_le(sel, 1'b0, 4'h0);
        check("err_on_le", err_s, !ok);
        check("busy_after_le", busy_s, ok);
    endtask

    // Entered one negedge after acceptance; records dout every cycle until busy falls
    task automatic capture(input int sel, input int nn, input int sd, input int chain_n,
                           input int poke, output int cyc);
        int bad, lim;
        cur_sel = sel;
        pay.delete();
        for (int i = 0; i < nn; i++) pay.push_back((sel == 0) ? mq_a.pop_front() : mq_b.pop_front());
        build_exp(nn);
        lim = exp_bits.size() * sd;
        cyc = 0;
        bad = 0;
        while (busy_s && cyc < lim + 50) begin
            if (poke >= 0 && cyc == poke + 1) begin
                set_le(sel, 1'b0, 4'h0);
                check("err_le_while_busy", err_s, 1'b1);
            end
            if (cyc >= lim || dout_s !== exp_bits[cyc / sd]) bad++;
            if (poke >= 0 && cyc == poke) set_le(sel, 1'b1, 4'h1);
            @(negedge clk);
            cyc++;
        end
        check("frame_cycles", cyc, lim);
        check("dout_bad_cycles", bad, 0);
        check("done_at_end", done_s, 1'b1);
        check("idle_dout", dout_s, 1'b0);
        if (chain_n != 0) begin
            set_le(sel, 1'b1, 4'(chain_n));
            @(negedge clk);
            set_le(sel, 1'b0, 4'h0);
            check("chain_err", err_s, 1'b0);
            check("chain_busy", busy_s, 1'b1);
        end else begin
            @(negedge clk);
            check("done_one_cycle", done_s, 1'b0);
        end
    endtask

    initial begin
        bit ok;
        int cyc, nn, k;
        rst_n = 1'b0;
        set_wr(0, 1'b0, 8'h00); set_le(0, 1'b0, 4'h0);
        set_wr(1, 1'b0, 8'h00); set_le(1, 1'b0, 4'h0);
        repeat (3) @(negedge clk);
        check("rst_dout", dout_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_err", err_a, 1'b0);
        check("rst_ovf", ovf_a, 1'b0);
        check("rst_cnt", cnt_a, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single C0 frame, SLOT_DIV=1 then SLOT_DIV=3
        push(0, 8'hC0);
        issue_le(0, 1, ok);
        check("single_accept", ok, 1'b1);
        if (ok) capture(0, 1, 1, 0, -1, cyc);
        check("single_len", cyc, frame_slots(1));
        push(1, 8'hC0);
        issue_le(1, 1, ok);
        if (ok) capture(1, 1, 3, 0, -1, cyc);
        check("div3_len", cyc, frame_slots(1) * 3);

        // Back-to-back frames with the second le in the done cycle
        push(0, 8'hC0); push(0, 8'hAA); push(0, 8'hDD); push(0, 8'hAE);
        issue_le(0, 2, ok);
        if (ok) begin
            capture(0, 2, 1, 2, -1, cyc);
            capture(0, 2, 1, 0, -1, cyc);
        end
        check("b2b_cnt", cnt_a, 0);

        // le during a frame is rejected and not queued
        push(0, 8'($urandom)); push(0, 8'($urandom));
        issue_le(0, 2, ok);
        if (ok) capture(0, 2, 1, 0, 30, cyc);
        check("poke_cnt", cnt_a, 0);

        // FIFO boundaries
        for (int i = 0; i < 17; i++) push(0, 8'($urandom));
        check("full_cnt", cnt_a, 16);
        issue_le(0, 0, ok);
        issue_le(0, 15, ok);
        if (ok) capture(0, 15, 1, 0, -1, cyc);
        push(0, 8'($urandom));
        issue_le(0, 3, ok);
        check("short_fifo_rejected", ok, 1'b0);
        issue_le(0, 2, ok);
        if (ok) capture(0, 2, 1, 0, -1, cyc);
        check("drain_cnt", cnt_a, 0);

        // Random frames on both instances
        for (int r = 0; r < 8; r++) begin
            int sel;
            sel = (r % 4 == 3) ? 1 : 0;
            k = $urandom_range(0, 6);
            for (int i = 0; i < k && qsize(sel) < 16; i++) push(sel, 8'($urandom));
            nn = $urandom_range(1, 8);
            issue_le(sel, nn, ok);
            if (ok) capture(sel, nn, (sel == 0) ? 1 : 3, 0, -1, cyc);
            check("rand_cnt", cnt_s, qsize(sel));
        end

        // Reset in the middle of DATA
        while (mq_a.size() < 3) push(0, 8'($urandom));
        issue_le(0, 3, ok);
        repeat (25) @(negedge clk);
        rst_n = 1'b0;
        #1;
        cur_sel = 0;
        check("midrst_dout", dout_a, 1'b0);
        check("midrst_busy", busy_a, 1'b0);
        check("midrst_cnt", cnt_a, 0);
        mq_a.delete();
        mq_b.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue_le(0, 1, ok);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
